morse_keyer_ctrl: RTL and testbench

Timing controller that turns a single Morse key line into dot/dash symbols. It drives the shift enable and clear of the per-letter code register (built from mydffe cells) and flags letter and word boundaries for the downstream decoder. It sits between the key input and the code register / letter lookup.

---
 rtl/morse_keyer_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_morse_keyer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer_ctrl.sv
// morse_keyer_ctrl: turns a single Morse key line into dot/dash symbols,
// drives shift-enable/clear of the per-letter code register and flags
// letter and word boundaries for the downstream decoder.
// Optional feature macro: KEY_SYNC_EN (2-flop synchronizer on key_in).
module morse_keyer_ctrl #(
  parameter int UNIT_CYCLES = 6000000,
  parameter int CNT_W       = 23,
  parameter int MAX_SYMBOLS = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_in,
  output logic       sym_valid,
  output logic       sym_bit,
  output logic [2:0] code_len,
  output logic       code_clr,
  output logic       letter_done,
  output logic       word_done,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // Last value of the unit sub-counter before it wraps into a new unit.
  localparam logic [CNT_W-1:0] UCNT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] UCNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       MAX_LEN   = 3'(MAX_SYMBOLS);

  // Key level as seen by the FSM.
  logic key;

`ifdef KEY_SYNC_EN
  logic [1:0] sync_reg;

  // Two-stage synchronizer for the asynchronous key line.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], key_in};
    end
  end

  assign key = sync_reg[1];
`else
  assign key = key_in;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] ucnt_reg, ucnt_next;
  logic [2:0]       dur_reg, dur_next;
  logic [2:0]       code_len_reg, code_len_next;
  logic             overflow_reg, overflow_next;
  logic             sym_valid_reg, sym_valid_next;
  logic             sym_bit_reg, sym_bit_next;
  logic             letter_done_reg, letter_done_next;
  logic             code_clr_reg, code_clr_next;
  logic             word_done_reg, word_done_next;
  logic             busy_reg, busy_next;

  // Counter helpers: a wrap closes one Morse time unit; dur saturates at 7.
  logic             wrap;
  logic [CNT_W-1:0] ucnt_inc;
  logic [2:0]       dur_inc;

  assign wrap     = (ucnt_reg == UCNT_LAST);
  assign ucnt_inc = wrap ? '0 : (ucnt_reg + UCNT_ONE);
  assign dur_inc  = !wrap ? dur_reg :
                    (dur_reg == 3'd7) ? 3'd7 : (dur_reg + 3'd1);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg       <= IDLE;
      ucnt_reg        <= '0;
      dur_reg         <= 3'd0;
      code_len_reg    <= 3'd0;
      overflow_reg    <= 1'b0;
      sym_valid_reg   <= 1'b0;
      sym_bit_reg     <= 1'b0;
      letter_done_reg <= 1'b0;
      code_clr_reg    <= 1'b0;
      word_done_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ucnt_reg        <= ucnt_next;
      dur_reg         <= dur_next;
      code_len_reg    <= code_len_next;
      overflow_reg    <= overflow_next;
      sym_valid_reg   <= sym_valid_next;
      sym_bit_reg     <= sym_bit_next;
      letter_done_reg <= letter_done_next;
      code_clr_reg    <= code_clr_next;
      word_done_reg   <= word_done_next;
      busy_reg        <= busy_next;
    end
  end

  // Next-state, counting, symbol classification and boundary detection.
  always_comb begin
    state_next       = state_reg;
    ucnt_next        = ucnt_reg;
    dur_next         = dur_reg;
    code_len_next    = code_len_reg;
    overflow_next    = overflow_reg;
    sym_valid_next   = 1'b0;
    sym_bit_next     = sym_bit_reg;
    letter_done_next = 1'b0;
    code_clr_next    = 1'b0;
    word_done_next   = 1'b0;

    // Overflow stays visible through the letter_done cycle, then clears.
    if (letter_done_reg) begin
      overflow_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        if (key) begin
          state_next = MARK;
          ucnt_next  = '0;
          dur_next   = 3'd0;
        end
      end

      MARK: begin
        if (key) begin
          ucnt_next = ucnt_inc;
          dur_next  = dur_inc;
        end else begin
          state_next = SPACE;
          ucnt_next  = '0;
          dur_next   = 3'd0;
          // Marks of two units or more are dashes.
          if (code_len_reg < MAX_LEN) begin
            sym_valid_next = 1'b1;
            sym_bit_next   = (dur_reg >= 3'd2);
            code_len_next  = code_len_reg + 3'd1;
          end else begin
            overflow_next = 1'b1;
          end
        end
      end

      SPACE: begin
        if (key) begin
          // Same letter if before the letter gap, otherwise a new letter;
          // either way code_len already reflects the right context.
          state_next = MARK;
          ucnt_next  = '0;
          dur_next   = 3'd0;
        end else begin
          ucnt_next = ucnt_inc;
          dur_next  = dur_inc;
          // Third unit of silence closes the letter (only if one exists).
          if (wrap && (dur_reg == 3'd2) && (code_len_reg != 3'd0)) begin
            letter_done_next = 1'b1;
            code_clr_next    = 1'b1;
            code_len_next    = 3'd0;
          end
          // Seventh unit of silence closes the word and idles the block.
          if (wrap && (dur_reg == 3'd6)) begin
            word_done_next = 1'b1;
            state_next     = IDLE;
            ucnt_next      = '0;
            dur_next       = 3'd0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        ucnt_next  = '0;
        dur_next   = 3'd0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign sym_valid   = sym_valid_reg;
  assign sym_bit     = sym_bit_reg;
  assign code_len    = code_len_reg;
  assign code_clr    = code_clr_reg;
  assign letter_done = letter_done_reg;
  assign word_done   = word_done_reg;
  assign overflow    = overflow_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// tb_morse_keyer_ctrl: directed and randomized key sequences checked every
// cycle against a run-length reference model of the keyer rules.
// Honors KEY_SYNC_EN by delaying the model's view of the key by 2 samples.
module tb_morse_keyer_ctrl;

  localparam int U  = 4;
  localparam int CW = 3;
  localparam int MS = 5;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_in;
  logic       sym_valid, sym_bit, code_clr, letter_done, word_done, overflow, busy;
  logic [2:0] code_len;

  morse_keyer_ctrl #(
    .UNIT_CYCLES (U),
    .CNT_W       (CW),
    .MAX_SYMBOLS (MS)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .key_in      (key_in),
    .sym_valid   (sym_valid),
    .sym_bit     (sym_bit),
    .code_len    (code_len),
    .code_clr    (code_clr),
    .letter_done (letter_done),
    .word_done   (word_done),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: tracks the length of the current high run (hi_n) and
  // low run (lo_n) in samples; boundaries follow directly from run lengths.
  int hi_n    = 0;
  int lo_n    = 0;
  bit session = 0;
  int e_len   = 0;
  bit e_sv = 0, e_sb = 0, e_ld = 0, e_cc = 0, e_wd = 0, e_ovf = 0, e_busy = 0;
`ifdef KEY_SYNC_EN
  bit s0 = 0, s1 = 0;
`endif

  function automatic void model_edge(bit k, bit r);
    bit kf;
    bit prev_ld;
`ifdef KEY_SYNC_EN
    kf = s1;
    if (r) begin
      s0 = 0;
      s1 = 0;
    end else begin
      s1 = s0;
      s0 = k;
    end
`else
    kf = k;
`endif
    if (r) begin
      hi_n = 0; lo_n = 0; session = 0; e_len = 0;
      e_sv = 0; e_sb = 0; e_ld = 0; e_cc = 0; e_wd = 0; e_ovf = 0; e_busy = 0;
      return;
    end
    prev_ld = e_ld;
    e_sv = 0; e_ld = 0; e_cc = 0; e_wd = 0;
    if (prev_ld) e_ovf = 0;
    if (kf) begin
      if (hi_n == 0) begin
        hi_n    = 1;
        lo_n    = 0;
        session = 1;
      end else begin
        hi_n++;
      end
    end else if (session) begin
      if (hi_n > 0) begin
        // Mark of N samples spans (N-1)/U units; 2 or more units is a dash.
        if (e_len < MS) begin
          e_sv = 1;
          e_sb = ((hi_n - 1) / U) >= 2;
          e_len++;
        end else begin
          e_ovf = 1;
        end
        hi_n = 0;
        lo_n = 1;
      end else begin
        lo_n++;
        if (lo_n == 3 * U + 1 && e_len > 0) begin
          e_ld  = 1;
          e_cc  = 1;
          e_len = 0;
        end
        if (lo_n == 7 * U + 1) begin
          e_wd    = 1;
          session = 0;
          lo_n    = 0;
        end
      end
    end
    e_busy = session;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: drive, let the DUT and model advance, compare off-edge.
  task automatic step(input bit k, input bit r);
    key_in = k;
    clr    = r;
    @(posedge clk);
    model_edge(k, r);
    @(negedge clk);
    check("sym_valid",   {3'b0, sym_valid},   {3'b0, e_sv});
    check("sym_bit",     {3'b0, sym_bit},     {3'b0, e_sb});
    check("code_len",    {1'b0, code_len},    4'(e_len));
    check("code_clr",    {3'b0, code_clr},    {3'b0, e_cc});
    check("letter_done", {3'b0, letter_done}, {3'b0, e_ld});
    check("word_done",   {3'b0, word_done},   {3'b0, e_wd});
    check("overflow",    {3'b0, overflow},    {3'b0, e_ovf});
    check("busy",        {3'b0, busy},        {3'b0, e_busy});
  endtask

  task automatic run(input bit k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  // One transaction: a mark of hi samples followed by lo low samples.
  task automatic transact(input int hi, input int lo);
    $display("txn: mark %0d samples, space %0d samples", hi, lo);
    run(1'b1, hi);
    run(1'b0, lo);
  endtask

  initial begin
    key_in = 1'b0;
    clr    = 1'b1;
    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run(1'b0, 3);

    // Dot: 5 samples high, then past the word gap
    transact(5, 35);
    // Dash then letter gap, then word gap
    transact(12, 35);
    // Dot, short gap, dash, 29 low
    transact(5, 5);
    transact(12, 29);
    run(1'b0, 4);
    // Six dots: sixth is dropped, overflow held through letter_done
    for (int i = 0; i < 5; i++) transact(5, 5);
    transact(5, 35);
    // Dot/dash boundary at 8 vs 9 samples, single-sample mark
    transact(8, 5);
    transact(9, 5);
    transact(1, 35);
    // Letter gap boundary: 12 low keeps the letter, 13 closes it
    transact(5, 12);
    transact(5, 13);
    // Word gap boundary: 28 low then mark, then 29 low
    transact(5, 28);
    transact(5, 29);
    // Long mark (dur saturates, still a dash)
    transact(40, 35);
    // Reset mid-mark with key held
    $display("txn: reset mid-mark");
    run(1'b1, 6);
    step(1'b1, 1'b1);
    run(1'b1, 9);
    run(1'b0, 35);
    // Reset mid-space
    $display("txn: reset mid-space");
    transact(5, 10);
    step(1'b0, 1'b1);
    run(1'b0, 3);

    // Randomized mark/space sequences with occasional resets
    for (int i = 0; i < 70; i++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(1, 14));
      lo = int'($urandom_range(1, 32));
      transact(hi, lo);
      if ($urandom_range(0, 15) == 0) begin
        $display("txn: random reset");
        step(($urandom_range(0, 1) == 1), 1'b1);
      end
    end
    run(1'b0, 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
